// File: rtl/hwpe_stream_sidech_credit_tx_if.sv
// Stream interface carrying payload beats with byte strobes and a
// valid/ready handshake. The producer side uses the source modport,
// the consumer side uses the sink modport.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (
        output valid,
        output data,
        output strb,
        input  ready
    );

    modport sink (
        input  valid,
        input  data,
        input  strb,
        output ready
    );
endinterface

// File: rtl/hwpe_stream_sidech_credit_tx.sv
// Credit-based transmitter: forwards accepted stream beats (payload,
// strobes and sidechannel) over a ready-less link to a remote receiver.
// A credit counter tracks free entries in the receiver FIFO; the upstream
// ready is taken from the registered FSM state only, so neither credit_i
// nor push valid has a combinational path to it.
module hwpe_stream_sidech_credit_tx #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SIDECH_WIDTH = 1,
    parameter int unsigned CREDITS      = 8,
    localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
    localparam int unsigned CNT_WIDTH   = $clog2(CREDITS + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    hwpe_stream_intf_stream.sink    push_i,
    input  logic [SIDECH_WIDTH-1:0] sidech_i,
    output logic                    tx_valid_o,
    output logic [DATA_WIDTH-1:0]   tx_data_o,
    output logic [STRB_WIDTH-1:0]   tx_strb_o,
    output logic [SIDECH_WIDTH-1:0] tx_sidech_o,
    input  logic                    credit_i,
    output logic [CNT_WIDTH-1:0]    credits_o,
    output logic                    idle_o,
    output logic                    starved_o,
    output logic                    err_o
);

    localparam logic [CNT_WIDTH-1:0] CREDITS_MAX = CNT_WIDTH'(CREDITS);
    localparam logic [CNT_WIDTH-1:0] ONE         = CNT_WIDTH'(1);

    // RUN while at least one credit remains, STARVED when none do.
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_STARVED = 1'b1
    } state_t;

    state_t                  state_reg,    state_next;
    logic [CNT_WIDTH-1:0]    credit_reg,   credit_next;
    logic                    err_reg,      err_next;
    logic                    tx_valid_reg, tx_valid_next;
    logic [DATA_WIDTH-1:0]   tx_data_reg,  tx_data_next;
    logic [STRB_WIDTH-1:0]   tx_strb_reg,  tx_strb_next;
    logic [SIDECH_WIDTH-1:0] tx_sidech_reg, tx_sidech_next;

    logic ready;
    logic accept;

    // Ready depends on the registered state only.
    assign ready  = (state_reg == ST_RUN);
    assign accept = push_i.valid & ready;

    // Next-state, credit bookkeeping and output-register inputs.
    always_comb begin
        state_next     = state_reg;
        credit_next    = credit_reg;
        err_next       = err_reg;
        tx_valid_next  = 1'b0;
        tx_data_next   = '0;
        tx_strb_next   = '0;
        tx_sidech_next = '0;

        // Credit counter: a returned credit and a sent beat in the same
        // cycle cancel out. A credit arriving with the counter already full
        // is a protocol violation: saturate and flag it.
        unique case ({accept, credit_i})
            2'b10: begin
                credit_next = credit_reg - ONE;
            end
            2'b01: begin
                if (credit_reg == CREDITS_MAX) begin
                    err_next = 1'b1;
                end else begin
                    credit_next = credit_reg + ONE;
                end
            end
            default: begin
                credit_next = credit_reg;
            end
        endcase

        // The state mirrors credit_reg == 0 at all times.
        unique case (state_reg)
            ST_RUN: begin
                if (accept && !credit_i && (credit_reg == ONE)) begin
                    state_next = ST_STARVED;
                end
            end
            ST_STARVED: begin
                if (credit_i) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        // Outgoing beat is registered; payload is forced to zero when idle.
        if (accept) begin
            tx_valid_next  = 1'b1;
            tx_data_next   = push_i.data;
            tx_strb_next   = push_i.strb;
            tx_sidech_next = sidech_i;
        end
    end

    // State register; reset and clear restore full credits and drop any
    // beat presented in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_reg     <= ST_RUN;
            credit_reg    <= CREDITS_MAX;
            err_reg       <= 1'b0;
            tx_valid_reg  <= 1'b0;
            tx_data_reg   <= '0;
            tx_strb_reg   <= '0;
            tx_sidech_reg <= '0;
        end else begin
            state_reg     <= state_next;
            credit_reg    <= credit_next;
            err_reg       <= err_next;
            tx_valid_reg  <= tx_valid_next;
            tx_data_reg   <= tx_data_next;
            tx_strb_reg   <= tx_strb_next;
            tx_sidech_reg <= tx_sidech_next;
        end
    end

    assign push_i.ready = ready;
    assign tx_valid_o   = tx_valid_reg;
    assign tx_data_o    = tx_data_reg;
    assign tx_strb_o    = tx_strb_reg;
    assign tx_sidech_o  = tx_sidech_reg;
    assign credits_o    = credit_reg;
    assign idle_o       = (credit_reg == CREDITS_MAX);
    assign starved_o    = (state_reg == ST_STARVED);
    assign err_o        = err_reg;

endmodule

// File: tb/tb_hwpe_stream_sidech_credit_tx.sv
// Randomised plus directed bench for the credit transmitter. A driver issues
// one cycle of stimulus per step and updates an abstract model (integer credit
// count, sticky error, queue of expected beats); a monitor on the falling edge
// compares DUT outputs against the model and pops expected beats.
module tb_hwpe_stream_sidech_credit_tx;

    localparam int DW = 32;
    localparam int SW = 1;
    localparam int NC = 8;
    localparam int CW = $clog2(NC + 1);

    typedef struct {
        logic [DW-1:0]   d;
        logic [DW/8-1:0] s;
        logic [SW-1:0]   sc;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic [SW-1:0] sidech;
    logic credit;
    logic tx_valid;
    logic [DW-1:0] tx_data;
    logic [DW/8-1:0] tx_strb;
    logic [SW-1:0] tx_sidech;
    logic [CW-1:0] credits;
    logic idle;
    logic starved;
    logic err;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push ();

    hwpe_stream_sidech_credit_tx #(
        .DATA_WIDTH  (DW),
        .SIDECH_WIDTH(SW),
        .CREDITS     (NC)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clear_i    (clear),
        .push_i     (push),
        .sidech_i   (sidech),
        .tx_valid_o (tx_valid),
        .tx_data_o  (tx_data),
        .tx_strb_o  (tx_strb),
        .tx_sidech_o(tx_sidech),
        .credit_i   (credit),
        .credits_o  (credits),
        .idle_o     (idle),
        .starved_o  (starved),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    tx_count = 0;
    bit    started = 1'b0;
    int    m_credits = NC;
    bit    m_err = 1'b0;
    beat_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; model updated with the rules of the link.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [DW/8-1:0] s,
                        input logic [SW-1:0] sc, input logic cr, input logic clr, input logic rn);
        bit acc;
        push.valid = v;
        push.data  = d;
        push.strb  = s;
        sidech     = sc;
        credit     = cr;
        clear      = clr;
        rst_n      = rn;
        @(posedge clk);
        if (!rn || clr) begin
            m_credits = NC;
            m_err     = 1'b0;
        end else begin
            acc = v && (m_credits > 0);
            if (acc) exp_q.push_back('{d: d, s: s, sc: sc});
            if (acc && !cr) m_credits--;
            else if (cr && !acc) begin
                if (m_credits == NC) m_err = 1'b1;
                else m_credits++;
            end
        end
        started = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic idle_step();
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic push_rand();
        step(1'b1, DW'($urandom), (DW/8)'($urandom), SW'($urandom), 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: one line per transaction, checks every cycle.
    always @(negedge clk) begin
        if (started) begin
            beat_t e;
            check("tx_valid", tx_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tx_count++;
                $display("beat %0d data=%h strb=%h sidech=%h", tx_count, tx_data, tx_strb, tx_sidech);
                check("tx_data", tx_data, e.d);
                check("tx_strb", tx_strb, e.s);
                check("tx_sidech", tx_sidech, e.sc);
            end else begin
                check("tx_zero", {tx_data, tx_strb, tx_sidech}, '0);
            end
            check("credits", credits, m_credits);
            check("ready", push.ready, m_credits > 0);
            check("idle", idle, m_credits == NC);
            check("starved", starved, m_credits == 0);
            check("err", err, m_err);
        end
    end

    initial begin
        int c0;
        push.valid = 1'b0;
        push.data  = '0;
        push.strb  = '0;
        sidech = '0;
        credit = 1'b0;
        clear  = 1'b0;
        rst_n  = 1'b0;
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h1234, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_credits", credits, NC);
        check("reset_ready", push.ready, 1'b1);
        check("reset_tx_valid", tx_valid, 1'b0);

        // Eight beats drain all credits; the last two presentations stall.
        c0 = tx_count;
        for (int i = 0; i < 10; i++) push_rand();
        check("drain_pulses", tx_count - c0, 8);
        check("drain_starved", starved, 1'b1);
        check("drain_credits", credits, 0);

        // One credit from STARVED lets exactly one more beat through.
        c0 = tx_count;
        step(1'b1, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1);
        check("credit_ready", push.ready, 1'b1);
        push_rand();
        push_rand();
        check("credit_one_beat", tx_count - c0, 1);
        check("credit_restarved", starved, 1'b1);

        // Accept and credit together at three credits: count unchanged.
        step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) push_rand();
        check("three_credits", credits, 3);
        step(1'b1, 32'h0BADF00D, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1);
        check("both_credits", credits, 3);
        check("both_tx_valid", tx_valid, 1'b1);

        // Credit overflow at full count is sticky until clear.
        step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        check("ovf_credits", credits, NC);
        check("ovf_err", err, 1'b1);
        for (int i = 0; i < 20; i++) idle_step();
        check("ovf_sticky", err, 1'b1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
        check("ovf_cleared", err, 1'b0);

        // Payload passthrough and zeroing.
        step(1'b1, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
        check("pay_data", tx_data, 32'hDEADBEEF);
        check("pay_strb", tx_strb, 4'hF);
        check("pay_sidech", tx_sidech, 1'b1);
        idle_step();
        check("pay_zero", {tx_valid, tx_data, tx_strb, tx_sidech}, '0);

        // Reset while STARVED with a beat presented.
        for (int i = 0; i < 8; i++) push_rand();
        check("pre_rst_starved", starved, 1'b1);
        step(1'b1, 32'hCAFE0001, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_no_tx", tx_valid, 1'b0);
        check("rst_credits", credits, NC);
        check("rst_idle", idle, 1'b1);
        check("rst_ready", push.ready, 1'b1);

        // Random traffic, returned credits, occasional clear/reset.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, DW'($urandom), (DW/8)'($urandom), SW'($urandom),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 149) != 0);
        end
        idle_step();
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_sidech_credit_tx.md
HWPE_STREAM_SIDECH_CREDIT_TX -- requirements
Module: hwpe_stream_sidech_credit_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 32: payload width in bits; SHALL be a multiple of 8.
REQ-002 Parameter SIDECH_WIDTH, default 1: sidechannel width in bits.
REQ-003 Parameter CREDITS, default 8: depth of the remote receiver FIFO, i.e. the initial credit count; SHALL be >= 1.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_ni  input  1  reset; synchronous, active-low.
REQ-006 clear_i  input  1  synchronous clear; same effect as reset.
REQ-007 push_i  hwpe_stream_intf_stream.sink  DATA_WIDTH data, DATA_WIDTH/8 strb  upstream beats with valid/ready handshake.
REQ-008 sidech_i  input  SIDECH_WIDTH  sidechannel, sampled together with push_i on handshake.
REQ-009 tx_valid_o  output  1  one-cycle pulse per beat sent to the remote receiver; the link has no ready.
REQ-010 tx_data_o  output  DATA_WIDTH  beat payload.
REQ-011 tx_strb_o  output  DATA_WIDTH/8  beat byte strobes.
REQ-012 tx_sidech_o  output  SIDECH_WIDTH  beat sidechannel.
REQ-013 credit_i  input  1  one-cycle pulse; the receiver has freed one entry.
REQ-014 credits_o  output  $clog2(CREDITS+1)  current credit count.
REQ-015 idle_o  output  1  high when credits_o == CREDITS (every sent beat has been returned).
REQ-016 starved_o  output  1  high in state STARVED.
REQ-017 err_o  output  1  sticky credit-overflow error.

Function
REQ-018 A credit counter credit_q SHALL hold the number of beats the receiver can still accept.
REQ-019 FSM states: RUN (credit_q > 0) and STARVED (credit_q == 0); the state SHALL always be consistent with credit_q.
REQ-020 push_i.ready SHALL be 1 in RUN and 0 in STARVED, driven from registered state only (no combinational path from credit_i or push_i.valid).
REQ-021 Handshake: a beat is accepted when push_i.valid & push_i.ready; push_i.valid without ready SHALL be held by upstream and SHALL NOT change state.
REQ-022 On acceptance, tx_valid_o SHALL be 1 on the next cycle, with tx_data_o/tx_strb_o/tx_sidech_o equal to the accepted push_i.data/push_i.strb/sidech_i. Latency is exactly 1 cycle.
REQ-023 Back-to-back acceptances SHALL produce back-to-back tx_valid_o pulses at one beat per cycle while credits remain.
REQ-024 When tx_valid_o is 0, tx_data_o, tx_strb_o and tx_sidech_o SHALL be all-zero.
REQ-025 Credit update per cycle: accept only -> credit_q-1; credit_i only -> credit_q+1; both or neither -> unchanged.
REQ-026 RUN->STARVED when credit_q == 1, the cycle accepts a beat, and credit_i is 0; STARVED->RUN on any credit_i.
REQ-027 In STARVED, credit_i SHALL make push_i.ready 1 on the next cycle, giving a 1-cycle credit-to-ready latency.
REQ-028 Overflow: credit_i while credit_q == CREDITS and no acceptance SHALL leave credit_q at CREDITS (saturate) and SHALL set err_o.
REQ-029 err_o SHALL stay set until reset or clear_i.
REQ-030 credits_o SHALL equal credit_q; idle_o and starved_o SHALL be decoded from registered state.

Reset
REQ-031 When rst_ni is 0 or clear_i is 1 at a clock edge, the block SHALL set:
  - credit_q = CREDITS and state RUN
  - tx_valid_o = 0 and all tx_* data outputs = 0
  - err_o = 0
  - push_i.ready = 1 from the following cycle.
REQ-032 The block SHALL discard a beat presented in the same cycle as reset or clear: no tx_valid_o pulse and no credit consumed.
REQ-033 Reset or clear during STARVED SHALL restore full credits; credits returned afterwards for pre-reset beats count as overflow per REQ-028.

Verification
REQ-034 CREDITS=8, no credit_i, push_i.valid=1 for 10 cycles -> exactly 8 tx_valid_o pulses with payload matching in order; ready falls after the 8th accept; starved_o=1; credits_o=0.
REQ-035 From STARVED, one credit_i pulse -> ready=1 next cycle; exactly one further beat sent; back to STARVED.
REQ-036 credits_o=3, accept and credit_i in the same cycle -> credits_o stays 3; tx_valid_o=1 next cycle.
REQ-037 Idle with credits_o=8, credit_i pulse -> credits_o=8, err_o=1 and still 1 after 20 cycles; clear_i -> err_o=0.
REQ-038 Push data=32'hDEADBEEF, strb=4'hF, sidech=1 -> next cycle tx_data_o=32'hDEADBEEF, tx_strb_o=4'hF, tx_sidech_o=1; cycle after with no accept -> all zero.
REQ-039 rst_ni=0 for one cycle while STARVED and push_i.valid=1 -> no tx_valid_o; credits_o=8, idle_o=1, ready=1 afterwards.
